// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity-type codes and the
// 2-of-3 vote used by the receiver sampler.
package uart_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/rx_data_sampler.sv
// Captures the line at the two edges before mid-bit and votes with the live
// value, so sampled_bit is meaningful when edge_cnt == PRESCALE/2+1.
module rx_data_sampler
    import uart_pkg::*;
#(
    parameter int PRESCALE = 8,
    parameter int CW       = $clog2(PRESCALE)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rx_in,
    input  logic [CW-1:0] edge_cnt,
    output logic          sampled_bit
);

    localparam logic [CW-1:0] EDGE_A = CW'(PRESCALE / 2 - 1);
    localparam logic [CW-1:0] EDGE_B = CW'(PRESCALE / 2);

    logic sample_a_q;
    logic sample_b_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample_a_q <= 1'b0;
            sample_b_q <= 1'b0;
        end else begin
            if (edge_cnt == EDGE_A) sample_a_q <= rx_in;
            if (edge_cnt == EDGE_B) sample_b_q <= rx_in;
        end
    end

    assign sampled_bit = majority3(sample_a_q, sample_b_q, rx_in);

endmodule

// File: rtl/uart_rx.sv
// UART receiver: oversampled start detection, 8 data bits LSB first, optional
// parity, one stop bit; result and error flags are one-cycle pulses.
module uart_rx
    import uart_pkg::*;
#(
    parameter int PRESCALE = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_in,
    input  logic       parity_en,
    input  logic       parity_type,
    output logic [7:0] p_data,
    output logic       data_valid,
    output logic       parity_err,
    output logic       stop_err,
    output logic       busy,
    output logic [2:0] current_state
);

    localparam int CW = $clog2(PRESCALE);
    localparam logic [CW-1:0] EDGE_ONE  = CW'(1);
    localparam logic [CW-1:0] EDGE_LAST = CW'(PRESCALE - 1);
    localparam logic [CW-1:0] EDGE_MID  = CW'(PRESCALE / 2 + 1);

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_en_q, par_en_d;
    logic          par_type_q, par_type_d;
    logic          par_bad_q, par_bad_d;
    logic [7:0]    p_data_q, p_data_d;
    logic          dv_q, dv_d;
    logic          pe_q, pe_d;
    logic          se_q, se_d;
    logic          sampled_bit;
    logic          wrap;
    logic          mid;

    rx_data_sampler #(.PRESCALE(PRESCALE), .CW(CW)) u_sampler (
        .clk        (clk),
        .rst        (rst),
        .rx_in      (rx_in),
        .edge_cnt   (cnt_q),
        .sampled_bit(sampled_bit)
    );

    assign wrap = (cnt_q == EDGE_LAST);
    assign mid  = (cnt_q == EDGE_MID);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        par_en_d   = par_en_q;
        par_type_d = par_type_q;
        par_bad_d  = par_bad_q;
        p_data_d   = p_data_q;
        dv_d       = 1'b0;
        pe_d       = 1'b0;
        se_d       = 1'b0;

        if (state_q != ST_IDLE) cnt_d = wrap ? '0 : cnt_q + EDGE_ONE;

        case (state_q)
            ST_IDLE: begin
                // The detecting cycle itself is edge 0, so the counter resumes at 1.
                if (!rx_in) begin
                    state_d    = ST_START;
                    cnt_d      = EDGE_ONE;
                    bit_d      = 3'd0;
                    par_en_d   = parity_en;
                    par_type_d = parity_type;
                    par_bad_d  = 1'b0;
                end
            end
            ST_START: begin
                if (mid && sampled_bit) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (wrap) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (mid) shift_d = {sampled_bit, shift_q[7:1]};
                if (wrap) begin
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = par_en_q ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: begin
                if (mid) par_bad_d = (sampled_bit != ((^shift_q) ^ (par_type_q == PAR_ODD)));
                if (wrap) state_d = ST_STOP;
            end
            ST_STOP: begin
                // Leave for IDLE at mid-stop so a closely following start edge is not missed.
                if (mid) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    se_d    = ~sampled_bit;
                    pe_d    = par_bad_q;
                    if (sampled_bit && !par_bad_q) begin
                        dv_d     = 1'b1;
                        p_data_d = shift_q;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            bit_q      <= 3'd0;
            shift_q    <= 8'h00;
            par_en_q   <= 1'b0;
            par_type_q <= 1'b0;
            par_bad_q  <= 1'b0;
            p_data_q   <= 8'h00;
            dv_q       <= 1'b0;
            pe_q       <= 1'b0;
            se_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            par_en_q   <= par_en_d;
            par_type_q <= par_type_d;
            par_bad_q  <= par_bad_d;
            p_data_q   <= p_data_d;
            dv_q       <= dv_d;
            pe_q       <= pe_d;
            se_q       <= se_d;
        end
    end

    assign p_data        = p_data_q;
    assign data_valid    = dv_q;
    assign parity_err    = pe_q;
    assign stop_err      = se_q;
    assign busy          = (state_q != ST_IDLE);
    assign current_state = state_q;

endmodule
